mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM stage of the single-cycle RV64 datapath. Holds a 1024 x 64-bit data memory,
//   performs ld/sd at the byte address computed by the ALU, and forwards
//   writeback control/data fields (ALU result, Rd, MemtoReg, RegWrite, BranchTaken)
//   to the writeback stage.
// PARAMETERS
//   DEPTH   1024  number of 64-bit words in data memory
//   WIDTH   64    data / address width in bits
// PORTS
//   clk             in   1      rising-edge clock
//   reset           in   1      synchronous, active-high; clears memory
//   ALUResult       in   64     byte address for ld/sd (also result to forward)
//   WriteData       in   64     store data (rs2)
//   Rd              in   5      destination register index
//   Zero            in   1      ALU zero flag; accepted, not used internally
//   BranchTaken     in   1      branch decision from EX
//   MemRead         in   1      load enable
//   MemWrite        in   1      store enable
//   MemtoReg        in   1      WB mux select (forwarded)
//   RegWrite        in   1      register-file write enable (forwarded)
//   ReadData        out  64     load data
//   ALUResultOut    out  64     = ALUResult
//   RdOut           out  5      = Rd
//   BranchTakenOut  out  1      = BranchTaken
//   MemtoRegOut     out  1      = MemtoReg
//   RegWriteOut     out  1      = RegWrite
// BEHAVIOUR
//   - Word index = ALUResult >> 3; ALUResult[2:0] ignored (no byte/half/word access).
//   - In range iff ALUResult < DEPTH*8 (0x2000 for defaults); full 64 bits compared.
//   - Write: at posedge clk, if !reset && MemWrite && in range -> mem[index] <= WriteData.
//     Out-of-range writes are dropped, no side effects.
//   - Read: combinational. ReadData = (MemRead && in range && !reset) ? mem[index] : 0.
//     MemRead=0 or out-of-range -> ReadData = 0.
//   - MemRead and MemWrite both high: write occurs at the edge; ReadData shows the old
//     word until the edge, then the new word.
//   - Reset: at posedge clk with reset=1, every memory word is cleared to 0. Reset wins
//     over a simultaneous MemWrite. While reset=1, ReadData = 0.
//   - Pass-through outputs are purely combinational, zero latency, unaffected by reset.
//   - Power-up memory contents are 0 (initialised).
//   - Latency: store is visible to a read one clock edge after MemWrite is sampled.
//     Load data is available in the same cycle.
// TESTING
//   1. Store 0xDEADBEEFDEADBEEF @0x10, next cycle load @0x10 (Rd=13, MemtoReg=1, RegWrite=1)
//      -> ReadData=0xDEADBEEFDEADBEEF, RdOut=13, MemtoRegOut=1, RegWriteOut=1.
//   2. Boundaries: store 0xAAAA..AA @0x0 and 0x5555..55 @0x1FF8; read back both -> same
//      values. Load @0x2000 -> ReadData=0. Load of a never-written word @0x40 -> 0.
//   3. BranchTaken=1, Zero=1, MemRead=0, ALUResult=0x30 -> BranchTakenOut=1, ReadData=0,
//      ALUResultOut=0x30.
//   4. Store 0xFFFF..FF @0x0 and confirm by reading; pulse reset 1 cycle; load @0x0 -> 0.
//   5. ld/sd sequence: sd 0x9876543210FEDCBA @0x60, then ld @0x60 -> 0x9876543210FEDCBA.
//      Stores to 0x20 do not disturb 0x10 (both read back intact).
//   6. Simultaneous reset=1 and MemWrite=1 @0x50 -> word stays 0 after reset release.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the single-cycle RV64 datapath: a word-addressed data memory for
// ld/sd plus zero-latency forwarding of the writeback control/data fields.
module mem_stage #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       Rd,
  input  logic             Zero,
  input  logic             BranchTaken,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] ALUResultOut,
  output logic [4:0]       RdOut,
  output logic             BranchTakenOut,
  output logic             MemtoRegOut,
  output logic             RegWriteOut
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH * 8);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [AW-1:0]    index;
  logic             in_range;
  logic             unused_bits;

  // Full-width compare so high address bits can never alias into the array.
  assign in_range = (ALUResult < LIMIT);
  assign index    = ALUResult[AW+2:3];

  // Zero and the byte offset are accepted for interface compatibility only.
  assign unused_bits = ^{Zero, ALUResult[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite && in_range) begin
      mem[index] <= WriteData;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && in_range && !reset) begin
      ReadData = mem[index];
    end
  end

  assign ALUResultOut   = ALUResult;
  assign RdOut          = Rd;
  assign BranchTakenOut = BranchTaken;
  assign MemtoRegOut    = MemtoReg;
  assign RegWriteOut    = RegWrite;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expectations are queued when stimulus is driven
// and popped against DUT outputs half a cycle away from the rising edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] ALUResult = '0;
  logic [63:0] WriteData = '0;
  logic [4:0]  Rd = '0;
  logic        Zero = 1'b0;
  logic        BranchTaken = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemtoReg = 1'b0;
  logic        RegWrite = 1'b0;
  logic [63:0] ReadData;
  logic [63:0] ALUResultOut;
  logic [4:0]  RdOut;
  logic        BranchTakenOut;
  logic        MemtoRegOut;
  logic        RegWriteOut;

  mem_stage #(.DEPTH(1024), .WIDTH(64)) dut (
    .clk(clk), .reset(reset), .ALUResult(ALUResult), .WriteData(WriteData),
    .Rd(Rd), .Zero(Zero), .BranchTaken(BranchTaken), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ReadData(ReadData), .ALUResultOut(ALUResultOut), .RdOut(RdOut),
    .BranchTakenOut(BranchTakenOut), .MemtoRegOut(MemtoRegOut),
    .RegWriteOut(RegWriteOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [longint unsigned];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic in_range(input logic [63:0] a);
    return a < 64'h2000;
  endfunction

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    longint unsigned idx;
    idx = longint'(a >> 3);
    if (in_range(a) && model.exists(idx)) return model[idx];
    return '0;
  endfunction

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected nothing queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] wd,
                       input logic mr, input logic mw, input logic [4:0] rd,
                       input logic m2r, input logic rw, input logic bt,
                       input logic z, input logic rs);
    ALUResult = a; WriteData = wd; MemRead = mr; MemWrite = mw; Rd = rd;
    MemtoReg = m2r; RegWrite = rw; BranchTaken = bt; Zero = z; reset = rs;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    drive(a, d, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("st_readdata_idle", 64'h0);
    #1;
    pop_check(ReadData);
    if (in_range(a)) model[longint'(a >> 3)] = d;
  endtask

  task automatic load(input string tag, input logic [63:0] a, input logic [4:0] rd,
                      input logic m2r, input logic rw);
    @(negedge clk);
    drive(a, 64'h0, 1'b1, 1'b0, rd, m2r, rw, 1'b0, 1'b0, 1'b0);
    push(tag, mem_val(a));
    push({tag, "_alu"}, a);
    push({tag, "_rd"}, {59'd0, rd});
    push({tag, "_m2r"}, {63'd0, m2r});
    push({tag, "_rw"}, {63'd0, rw});
    #1;
    pop_check(ReadData);
    pop_check(ALUResultOut);
    pop_check({59'd0, RdOut});
    pop_check({63'd0, MemtoRegOut});
    pop_check({63'd0, RegWriteOut});
  endtask

  initial begin
    // Power-up contents
    load("powerup_0x40", 64'h40, 5'd1, 1'b0, 1'b0);

    // Store then load
    store(64'h10, 64'hDEADBEEFDEADBEEF);
    load("ld_0x10", 64'h10, 5'd13, 1'b1, 1'b1);

    // Boundaries and out-of-range accesses
    store(64'h0, 64'hAAAAAAAAAAAAAAAA);
    store(64'h1FF8, 64'h5555555555555555);
    load("ld_0x0", 64'h0, 5'd2, 1'b1, 1'b1);
    load("ld_0x1ff8", 64'h1FF8, 5'd3, 1'b1, 1'b0);
    load("ld_0x2000", 64'h2000, 5'd4, 1'b0, 1'b1);
    load("ld_unwritten_0x40", 64'h40, 5'd5, 1'b1, 1'b1);
    store(64'h2000, 64'h1234123412341234);
    store(64'h8000000000000010, 64'h0BADF00D0BADF00D);
    load("ld_0x0_after_oob", 64'h0, 5'd6, 1'b0, 1'b0);
    load("ld_0x10_after_oob", 64'h10, 5'd7, 1'b1, 1'b1);
    load("ld_0x1fff_offset", 64'h1FFF, 5'd8, 1'b1, 1'b1);
    load("ld_0x2007", 64'h2007, 5'd9, 1'b0, 1'b0);
    load("ld_high_alias", 64'h8000000000000010, 5'd10, 1'b1, 1'b1);

    // Branch forwarding with MemRead low
    @(negedge clk);
    drive(64'h30, 64'h0, 1'b0, 1'b0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("br_readdata", 64'h0);
    push("br_alu", 64'h30);
    push("br_taken", 64'h1);
    #1;
    pop_check(ReadData);
    pop_check(ALUResultOut);
    pop_check({63'd0, BranchTakenOut});

    // Reset clears memory; ReadData held at 0 while reset is high
    store(64'h0, 64'hFFFFFFFFFFFFFFFF);
    load("ld_ones_0x0", 64'h0, 5'd12, 1'b1, 1'b1);
    @(negedge clk);
    drive(64'h0, 64'h0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push("rst_readdata", 64'h0);
    push("rst_rd_passthru", 64'd14);
    #1;
    pop_check(ReadData);
    pop_check({59'd0, RdOut});
    model.delete();
    load("ld_0x0_post_reset", 64'h0, 5'd15, 1'b1, 1'b1);
    load("ld_0x10_post_reset", 64'h10, 5'd16, 1'b1, 1'b1);

    // ld/sd sequence and neighbour isolation
    store(64'h60, 64'h9876543210FEDCBA);
    load("ld_0x60", 64'h60, 5'd17, 1'b1, 1'b1);
    store(64'h10, 64'h1111111111111111);
    store(64'h20, 64'h2222222222222222);
    load("ld_0x10_iso", 64'h10, 5'd18, 1'b1, 1'b1);
    load("ld_0x20_iso", 64'h20, 5'd19, 1'b1, 1'b1);

    // Read and write together: old word before the edge, new word after
    @(negedge clk);
    drive(64'h60, 64'h0123456789ABCDEF, 1'b1, 1'b1, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push("rw_old", mem_val(64'h60));
    #1;
    pop_check(ReadData);
    @(posedge clk);
    #1;
    model[longint'(64'h60 >> 3)] = 64'h0123456789ABCDEF;
    push("rw_new", mem_val(64'h60));
    pop_check(ReadData);

    // Reset wins over a simultaneous store
    @(negedge clk);
    drive(64'h50, 64'hCAFECAFECAFECAFE, 1'b1, 1'b1, 5'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push("rst_wr_readdata", 64'h0);
    #1;
    pop_check(ReadData);
    model.delete();
    load("ld_0x50_after_rst_wr", 64'h50, 5'd22, 1'b1, 1'b1);
    load("ld_0x60_after_rst_wr", 64'h60, 5'd23, 1'b1, 1'b1);

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
